// File: rtl/interpolator.sv
// -----------------------------------------------------------------------------
// interpolator
//
// Integer-factor upsampler. Accepts one sample per valid/ready handshake and
// emits FACTOR output samples for it: either the sample repeated FACTOR times
// (hold mode) or the sample followed by FACTOR-1 zeros (zero-stuff mode).
// A new sample may be accepted on the last phase of the current one, so a
// continuously valid source produces a gapless output stream.
//
// Parameters
//   ARCHITECTURE  implementation select; only "BEHAVIORAL" is implemented
//   DATA_WIDTH    sample width in bits
//   FACTOR        interpolation ratio (>= 1)
//   ZERO_STUFF    0: hold mode, 1: zero-stuff mode
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   en          step enable; low freezes the block and blocks new input
//   data_in     input sample
//   in_valid    data_in is valid
//   in_ready    sample accepted this cycle when in_valid is high (combinational)
//   data_out    output sample (registered)
//   data_valid  data_out carries a new output this cycle (registered)
// -----------------------------------------------------------------------------
module interpolator #(
  parameter     ARCHITECTURE = "BEHAVIORAL",
  parameter int DATA_WIDTH   = 8,
  parameter int FACTOR       = 4,
  parameter int ZERO_STUFF   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid
);

  localparam int              PH_W = (FACTOR > 1) ? $clog2(FACTOR) : 1;
  localparam logic [PH_W-1:0] LAST = PH_W'(FACTOR - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  generate
    if (ARCHITECTURE == "BEHAVIORAL") begin : g_behavioral
      state_t                  state_q, state_d;
      logic [PH_W-1:0]         ph_q, ph_d;
      logic [DATA_WIDTH-1:0]   hold_q, hold_d;
      logic [DATA_WIDTH-1:0]   dout_q, dout_d;
      logic                    dv_q, dv_d;
      logic                    ready_core;
      logic                    accept;

      // rst gates only the visible in_ready. The next-state logic does not need
      // it because the registers are held in reset whenever rst is low, and
      // keeping the reset net out of the flop data paths keeps it a pure
      // asynchronous reset.
      assign ready_core = en & ((state_q == IDLE) | (ph_q == LAST));
      assign accept     = in_valid & ready_core;
      assign in_ready   = rst & ready_core;

      always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        state_d = state_q;
        ph_d    = ph_q;
        hold_d  = hold_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;

        if (en) begin
          if (accept) begin
            state_d = RUN;
            ph_d    = '0;
            hold_d  = data_in;
            dout_d  = data_in;
            dv_d    = 1'b1;
          end else if (state_q == RUN) begin
            if (ph_q != LAST) begin
              ph_d   = ph_q + 1'b1;
              dout_d = (ZERO_STUFF != 0) ? '0 : hold_q;
              dv_d   = 1'b1;
            end else begin
              // Last phase emitted and nothing new offered: go quiet,
              // data_out keeps its final value.
              state_d = IDLE;
            end
          end
        end
      end

      // NOTE: sequential state is written with non-blocking assignments so
      // every register samples the pre-edge values regardless of order.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q <= IDLE;
          ph_q    <= '0;
          hold_q  <= '0;
          dout_q  <= '0;
          dv_q    <= 1'b0;
        end else begin
          state_q <= state_d;
          ph_q    <= ph_d;
          hold_q  <= hold_d;
          dout_q  <= dout_d;
          dv_q    <= dv_d;
        end
      end

      assign data_out   = dout_q;
      assign data_valid = dv_q;
    end else begin : g_undefined
      // No other implementation exists; an unknown selection yields an
      // inert block rather than silently picking one.
      assign in_ready   = 1'b0;
      assign data_out   = '0;
      assign data_valid = 1'b0;
    end
  endgenerate

endmodule

// File: doc/interpolator.md
# interpolator

Integer-factor upsampler for the DSP blocks library. It is the transmit-side counterpart of `decimator`: it accepts one sample per valid/ready handshake and emits FACTOR output samples per input. Each output is either the held input sample or the input followed by FACTOR-1 zeros. It sits between a low-rate sample source and a full-rate consumer (filter, DAC path) on a single clock.

## Interface
- ARCHITECTURE, "BEHAVIORAL": implementation select; only "BEHAVIORAL" is defined.
- DATA_WIDTH, 8: sample width in bits.
- FACTOR, 4: interpolation ratio, integer ≥ 1. Phase counter width is max(1, clog2(FACTOR)).
- ZERO_STUFF, 0: 0 selects hold mode (sample repeated FACTOR times); 1 selects zero-stuff mode (sample, then FACTOR-1 zeros).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  step enable; low freezes the block.
- data_in  in  DATA_WIDTH  input sample.
- in_valid  in  1  data_in is valid.
- in_ready  out  1  the block accepts data_in this cycle (combinational).
- data_out  out  DATA_WIDTH  output sample (registered).
- data_valid  out  1  data_out is valid this cycle (registered).

## Operation
- States: IDLE (no sample loaded) and RUN (emitting phases of the held sample). Phase register `ph` runs 0..FACTOR-1 and holds the phase currently on data_out.
- in_ready = rst & en & (state==IDLE | ph==FACTOR-1). It is 0 while rst is low.
- Accept = in_valid & in_ready. On accept, the sample is latched into the hold register, state becomes RUN, and ph becomes 0. On the next edge, data_out = data_in and data_valid = 1.
- In RUN with en=1 and ph<FACTOR-1: ph increments, data_valid=1, and data_out = held sample (ZERO_STUFF=0) or 0 (ZERO_STUFF=1).
- In RUN at ph==FACTOR-1 with en=1:
  - If accept: load the new sample at ph=0. The output stream is gapless.
  - Else: state becomes IDLE, data_valid=0, and data_out keeps its last value.
- IDLE with no accept: data_valid=0 and data_out is held.
- en=0: no step. State, ph and the hold register are frozen, in_ready=0, data_valid is registered to 0, and data_out is held. When en returns to 1, emission resumes at the next pending phase. No phase is lost or repeated.
- FACTOR=1: every accepted sample produces exactly one output. In RUN, in_ready stays high, so full throughput is one sample per cycle.
- No arithmetic on the data path. Outputs are bit-exact copies of the input or all-zeros.

## Timing
- Reset (rst low, asynchronous): state=IDLE, ph=0, hold register=0, data_out=0, data_valid=0, in_ready=0. Release is synchronous to the next clk edge. The first accept is possible on the first edge with rst high.
- Latency: 1 cycle from the accept edge to the first output (data_valid high).
- Throughput: one input per FACTOR enabled cycles, with data_valid continuously high when in_valid is continuously high.
- Reset asserted mid-RUN clears immediately. The partially emitted sample is discarded and no further outputs are produced.
- in_valid high while in_ready is low has no effect. The source must hold data_in until in_ready is high.

## Test plan
- Reset: hold rst low for 3 cycles with in_valid=1 -> data_valid=0, data_out=0, in_ready=0 throughout; after release, in_ready=1 in IDLE.
- Hold mode, FACTOR=4: feed 0x11, 0x22 back-to-back with in_valid constantly 1 -> data_out = 11,11,11,11,22,22,22,22, data_valid high for all 8 cycles, in_ready high only on the 4th phase of each sample.
- Zero-stuff mode, FACTOR=4: feed 0xA5 once, then in_valid=0 -> data_out = A5,00,00,00; then data_valid=0 with data_out held at 00; state returns to IDLE.
- Enable stall: during hold-mode emission of 0x33, drop en for 2 cycles after phase 1 -> data_valid=0 for 2 cycles, in_ready=0; after en returns, phases 2 and 3 emit 33,33; exactly 4 valid outputs in total.
- Mid-operation reset: assert rst at phase 2 of 0x44 -> data_valid=0 and data_out=0 immediately; after release, a new sample 0x55 yields 55×4 with no residual 44.
- FACTOR=1 passthrough: a counter 0..9 on data_in with in_valid=1 -> data_out = 0..9, one per cycle, 1-cycle latency, data_valid continuously high.
